// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: sequences each instruction through IF/ID/EX/MEM/WB.
// Define MC_PERF_CNT_EN to add the cycle_cnt / retire_cnt performance counters.
module mc_ctrl_fsm (
    input  logic        clk,
    input  logic        resetn,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        alu_zero,
    input  logic        inst_ready,
    input  logic        mem_ready,
    output logic        inst_req,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] retire_cnt
`endif
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB
    } state_e;

    typedef enum logic [3:0] {
        C_ILLEGAL,
        C_R_ALU,
        C_I_ALU,
        C_LW,
        C_SW,
        C_BEQ,
        C_BNE,
        C_J,
        C_JAL,
        C_JR
    } class_e;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_SLTU = 3'b100;
    localparam logic [2:0] ALU_LUI  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS    = 2'b01;
    localparam logic [1:0] SRC_A_SHAMT = 2'b10;

    localparam logic [1:0] SRC_B_RT    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_BOFS  = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;
    class_e     instr_class;
    logic [2:0] ex_alu_op;
    logic       is_sll;

    // IR is stable from ID through WB, so decoding straight from opcode/funct is safe.
    always_comb begin
        instr_class = C_ILLEGAL;
        ex_alu_op   = ALU_ADD;
        case (opcode)
            6'b000000: begin
                instr_class = C_R_ALU;
                case (funct)
                    6'b100001: ex_alu_op = ALU_ADD;
                    6'b100011: ex_alu_op = ALU_SUB;
                    6'b100100: ex_alu_op = ALU_AND;
                    6'b100101: ex_alu_op = ALU_OR;
                    6'b101010: ex_alu_op = ALU_SLT;
                    6'b101011: ex_alu_op = ALU_SLTU;
                    6'b000000: ex_alu_op = ALU_SLL;
                    6'b001000: instr_class = C_JR;
                    default:   instr_class = C_ILLEGAL;
                endcase
            end
            6'b001001: begin instr_class = C_I_ALU; ex_alu_op = ALU_ADD;  end
            6'b001010: begin instr_class = C_I_ALU; ex_alu_op = ALU_SLT;  end
            6'b001011: begin instr_class = C_I_ALU; ex_alu_op = ALU_SLTU; end
            6'b001111: begin instr_class = C_I_ALU; ex_alu_op = ALU_LUI;  end
            6'b100011: instr_class = C_LW;
            6'b101011: instr_class = C_SW;
            6'b000100: instr_class = C_BEQ;
            6'b000101: instr_class = C_BNE;
            6'b000010: instr_class = C_J;
            6'b000011: instr_class = C_JAL;
            default:   instr_class = C_ILLEGAL;
        endcase
    end

    assign is_sll = (opcode == 6'b000000) && (funct == 6'b000000);

    always_comb begin
        // NOTE: every output and next-state value gets a default here so no path infers a latch.
        state_d    = state_q;
        illegal_d  = illegal_q;
        inst_req   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RT;
        alu_op     = ALU_AND;
        reg_write  = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALUOUT;

        unique case (state_q)
            S_INIT: state_d = S_IF;

            S_IF: begin
                inst_req  = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_ADD;
                if (inst_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_ALU;
                    state_d  = S_ID;
                end
            end

            S_ID: begin
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_BOFS;
                alu_op    = ALU_ADD;
                if (instr_class == C_ILLEGAL) begin
                    illegal_d = 1'b1;
                    state_d   = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end

            S_EX: begin
                case (instr_class)
                    C_R_ALU: begin
                        alu_src_a = is_sll ? SRC_A_SHAMT : SRC_A_RS;
                        alu_src_b = SRC_B_RT;
                        alu_op    = ex_alu_op;
                        state_d   = S_WB;
                    end
                    C_I_ALU: begin
                        alu_src_a = SRC_A_RS;
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ex_alu_op;
                        state_d   = S_WB;
                    end
                    C_LW, C_SW: begin
                        alu_src_a = SRC_A_RS;
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_ADD;
                        state_d   = S_MEM;
                    end
                    C_BEQ, C_BNE: begin
                        alu_src_a = SRC_A_RS;
                        alu_src_b = SRC_B_RT;
                        alu_op    = ALU_SUB;
                        pc_src    = PC_ALUOUT;
                        pc_write  = (instr_class == C_BEQ) ? alu_zero : !alu_zero;
                        state_d   = S_IF;
                    end
                    C_J: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                        state_d  = S_IF;
                    end
                    C_JAL: begin
                        // PC was already advanced in IF, so the link value is simply PC.
                        pc_write   = 1'b1;
                        pc_src     = PC_JUMP;
                        reg_write  = 1'b1;
                        reg_dst    = DST_RA;
                        mem_to_reg = WB_PC;
                        state_d    = S_IF;
                    end
                    C_JR: begin
                        pc_write = 1'b1;
                        pc_src   = PC_RS;
                        state_d  = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end

            S_MEM: begin
                if (instr_class == C_LW) begin
                    mem_read = 1'b1;
                    if (mem_ready) state_d = S_WB;
                end else if (instr_class == C_SW) begin
                    mem_write = 1'b1;
                    if (mem_ready) state_d = S_IF;
                end else begin
                    state_d = S_IF;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                if (instr_class == C_R_ALU) begin
                    reg_dst    = DST_RD;
                    mem_to_reg = WB_ALUOUT;
                end else if (instr_class == C_LW) begin
                    reg_dst    = DST_RT;
                    mem_to_reg = WB_MDR;
                end else begin
                    reg_dst    = DST_RT;
                    mem_to_reg = WB_ALUOUT;
                end
                state_d = S_IF;
            end

            default: state_d = S_INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments; all of them are reset since none is a memory array.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_INIT;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic        retire;

    // An instruction retires whenever control falls back into IF from a later state.
    assign retire = (state_d == S_IF) &&
                    ((state_q == S_ID) || (state_q == S_EX) ||
                     (state_q == S_MEM) || (state_q == S_WB));

    always_comb begin
        cycle_cnt_d  = cycle_cnt_q;
        retire_cnt_d = retire_cnt_q;
        if (state_q != S_INIT) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (retire)            retire_cnt_d = retire_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_cnt_q  <= 32'd0;
            retire_cnt_q <= 32'd0;
        end else begin
            cycle_cnt_q  <= cycle_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle vector table with a scoreboard
// queue, plus hand-built sequences for reset-in-MEM and sticky illegal.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  opcode, funct;
    logic        alu_zero, inst_ready, mem_ready;
    logic        inst_req, mem_read, mem_write, ir_write, pc_write;
    logic [1:0]  pc_src, alu_src_a, alu_src_b;
    logic [2:0]  alu_op;
    logic        reg_write;
    logic [1:0]  reg_dst, mem_to_reg;
    logic        illegal;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, retire_cnt;
`endif

    always #5 clk = ~clk;

    mc_ctrl_fsm dut (
        .clk        (clk),
        .resetn     (resetn),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .inst_ready (inst_ready),
        .mem_ready  (mem_ready),
        .inst_req   (inst_req),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal    (illegal)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
`endif
    );

    typedef struct packed {
        logic       inst_req;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       illegal;
    } out_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       ir;
        logic       mr;
        out_t       exp;
    } vec_t;

    vec_t  vecs[$];
    string names[$];
    out_t  exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  model_ill = 1'b0;
    out_t  act;

    assign act = {inst_req, mem_read, mem_write, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, illegal};

    task automatic check(input string name, input out_t got, input out_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic out_t o_none();
        out_t o = '0;
        o.illegal = model_ill;
        return o;
    endfunction

    function automatic out_t e_if(input logic rdy);
        out_t o = o_none();
        o.inst_req = 1'b1;
        o.src_b    = 2'b01;
        o.alu_op   = 3'b010;
        o.ir_write = rdy;
        o.pc_write = rdy;
        return o;
    endfunction

    function automatic out_t e_id();
        out_t o = o_none();
        o.src_b  = 2'b11;
        o.alu_op = 3'b010;
        return o;
    endfunction

    function automatic out_t e_ex(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op);
        out_t o = o_none();
        o.src_a  = a;
        o.src_b  = b;
        o.alu_op = op;
        return o;
    endfunction

    function automatic out_t e_br(input logic take);
        out_t o = e_ex(2'b01, 2'b00, 3'b110);
        o.pc_src   = 2'b01;
        o.pc_write = take;
        return o;
    endfunction

    function automatic out_t e_jmp(input logic [1:0] src);
        out_t o = o_none();
        o.pc_write = 1'b1;
        o.pc_src   = src;
        return o;
    endfunction

    function automatic out_t e_mem(input logic rd);
        out_t o = o_none();
        o.mem_read  = rd;
        o.mem_write = !rd;
        return o;
    endfunction

    function automatic out_t e_wb(input logic [1:0] dst, input logic [1:0] m2r);
        out_t o = o_none();
        o.reg_write  = 1'b1;
        o.reg_dst    = dst;
        o.mem_to_reg = m2r;
        return o;
    endfunction

    task automatic add(input string n, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic ir, input logic mr, input out_t e);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.ir = ir; v.mr = mr; v.exp = e;
        vecs.push_back(v);
        names.push_back(n);
    endtask

    task automatic fetch(input string n, input logic [5:0] op, input logic [5:0] fn);
        add($sformatf("%s IF", n), op, fn, 1'b0, 1'b1, 1'b0, e_if(1'b1));
        add($sformatf("%s ID", n), op, fn, 1'b0, 1'b0, 1'b0, e_id());
    endtask

    task automatic alu_instr(input string n, input logic [5:0] op, input logic [5:0] fn,
                             input logic [1:0] a, input logic [1:0] b,
                             input logic [2:0] aop, input logic [1:0] dst);
        fetch(n, op, fn);
        add($sformatf("%s EX", n), op, fn, 1'b0, 1'b0, 1'b0, e_ex(a, b, aop));
        add($sformatf("%s WB", n), op, fn, 1'b0, 1'b0, 1'b0, e_wb(dst, 2'b00));
    endtask

    // Drives one row per cycle just after the rising edge and compares at the falling edge.
    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            opcode     = vecs[i].op;
            funct      = vecs[i].fn;
            alu_zero   = vecs[i].z;
            inst_ready = vecs[i].ir;
            mem_ready  = vecs[i].mr;
            exp_q.push_back(vecs[i].exp);
            @(negedge clk);
            check(names[i], act, exp_q.pop_front());
            @(posedge clk);
            #1;
        end
        vecs.delete();
        names.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        out_t t;
        resetn = 1'b0; opcode = '0; funct = '0;
        alu_zero = 1'b0; inst_ready = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("in reset", act, out_t'(0));
        resetn = 1'b1;

        add("init", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, o_none());
        for (int i = 0; i < 3; i++) add("if wait", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, e_if(1'b0));
        alu_instr("addu", 6'b000000, 6'b100001, 2'b01, 2'b00, 3'b010, 2'b01);

        fetch("lw", 6'b100011, 6'd0);
        add("lw EX", 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, e_ex(2'b01, 2'b10, 3'b010));
        add("lw MEM1", 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, e_mem(1'b1));
        add("lw MEM2", 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, e_mem(1'b1));
        add("lw MEM3", 6'b100011, 6'd0, 1'b0, 1'b0, 1'b1, e_mem(1'b1));
        add("lw WB", 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, e_wb(2'b00, 2'b01));

        fetch("sw", 6'b101011, 6'd0);
        add("sw EX", 6'b101011, 6'd0, 1'b0, 1'b0, 1'b0, e_ex(2'b01, 2'b10, 3'b010));
        add("sw MEM", 6'b101011, 6'd0, 1'b0, 1'b0, 1'b1, e_mem(1'b0));

        fetch("beq z1", 6'b000100, 6'd0);
        add("beq z1 EX", 6'b000100, 6'd0, 1'b1, 1'b0, 1'b0, e_br(1'b1));
        fetch("beq z0", 6'b000100, 6'd0);
        add("beq z0 EX", 6'b000100, 6'd0, 1'b0, 1'b0, 1'b0, e_br(1'b0));
        fetch("bne z0", 6'b000101, 6'd0);
        add("bne z0 EX", 6'b000101, 6'd0, 1'b0, 1'b0, 1'b0, e_br(1'b1));
        fetch("bne z1", 6'b000101, 6'd0);
        add("bne z1 EX", 6'b000101, 6'd0, 1'b1, 1'b0, 1'b0, e_br(1'b0));

        fetch("jal", 6'b000011, 6'd0);
        t = e_jmp(2'b10);
        t.reg_write = 1'b1; t.reg_dst = 2'b10; t.mem_to_reg = 2'b10;
        add("jal EX", 6'b000011, 6'd0, 1'b0, 1'b0, 1'b0, t);
        fetch("j", 6'b000010, 6'd0);
        add("j EX", 6'b000010, 6'd0, 1'b0, 1'b0, 1'b0, e_jmp(2'b10));
        fetch("jr", 6'b000000, 6'b001000);
        add("jr EX", 6'b000000, 6'b001000, 1'b0, 1'b0, 1'b0, e_jmp(2'b11));

        alu_instr("sll",   6'b000000, 6'b000000, 2'b10, 2'b00, 3'b011, 2'b01);
        alu_instr("subu",  6'b000000, 6'b100011, 2'b01, 2'b00, 3'b110, 2'b01);
        alu_instr("and",   6'b000000, 6'b100100, 2'b01, 2'b00, 3'b000, 2'b01);
        alu_instr("or",    6'b000000, 6'b100101, 2'b01, 2'b00, 3'b001, 2'b01);
        alu_instr("slt",   6'b000000, 6'b101010, 2'b01, 2'b00, 3'b111, 2'b01);
        alu_instr("sltu",  6'b000000, 6'b101011, 2'b01, 2'b00, 3'b100, 2'b01);
        alu_instr("addiu", 6'b001001, 6'd0, 2'b01, 2'b10, 3'b010, 2'b00);
        alu_instr("slti",  6'b001010, 6'd0, 2'b01, 2'b10, 3'b111, 2'b00);
        alu_instr("sltiu", 6'b001011, 6'd0, 2'b01, 2'b10, 3'b100, 2'b00);
        alu_instr("lui",   6'b001111, 6'd0, 2'b01, 2'b10, 3'b101, 2'b00);

        fetch("bad op", 6'b111111, 6'd0);
        model_ill = 1'b1;
        add("after bad op", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, e_if(1'b0));
        alu_instr("addiu sticky", 6'b001001, 6'd0, 2'b01, 2'b10, 3'b010, 2'b00);
        run_vecs();

        // Reset asserted while lw waits in MEM: outputs must clear without a clock edge.
        fetch("lw2", 6'b100011, 6'd0);
        add("lw2 EX", 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, e_ex(2'b01, 2'b10, 3'b010));
        add("lw2 MEM", 6'b100011, 6'd0, 1'b0, 1'b0, 1'b0, e_mem(1'b1));
        run_vecs();
        resetn = 1'b0;
        #1;
        check("reset in MEM", act, out_t'(0));
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_ill = 1'b0;

        add("init2", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, o_none());
        add("if wait2", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, e_if(1'b0));
        fetch("bad funct", 6'b000000, 6'b111111);
        model_ill = 1'b1;
        add("after bad funct", 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, e_if(1'b0));
        run_vecs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle MIPS control unit. It is the driving end of the ALU interface: it sequences each instruction through fetch, decode, execute, memory and writeback.
- Per cycle it issues the ALU operation code, operand selects, datapath write-enables and memory handshakes. It consumes the ALU Zero flag for branches.
- Sits between the instruction/data memory ports and the datapath (PC, IR, register file, ALUOut, MDR).

Parameters:
- none. Fixed 32-bit MIPS subset.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU Zero flag
- inst_ready  in  1  instruction memory response valid
- mem_ready  in  1  data memory access complete
- inst_req  out  1  instruction fetch request
- mem_read  out  1  data read request
- mem_write  out  1  data write request
- ir_write  out  1  latch IR
- pc_write  out  1  update PC
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],00}, 11 rs
- alu_src_a  out  2  00 PC, 01 rs, 10 zero-extended shamt
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-extended imm, 11 sext imm<<2
- alu_op  out  3  AND 000, OR 001, ADD 010, SUB 110, SLL 011, SLTU 100, LUI 101, SLT 111
- reg_write  out  1  register file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- illegal  out  1  sticky flag: unsupported instruction decoded

Behaviour:
- States: INIT, IF, ID, EX, MEM, WB. Encoding is free.
- Async reset: state=INIT, illegal=0.
- INIT: all outputs 0. Next state is IF after one cycle.
- Outputs not listed for a state are 0.
- IF: inst_req=1; alu_src_a=00, alu_src_b=01, alu_op=ADD.
  - inst_ready=0: remain in IF, inst_req held high.
  - inst_ready=1 (same cycle): ir_write=1, pc_write=1, pc_src=00; next state ID.
- ID: alu_src_a=00, alu_src_b=11, alu_op=ADD (branch target captured in ALUOut).
  - Unsupported opcode/funct: set illegal; next state IF (instruction treated as NOP).
  - Otherwise next state EX.
- Supported set:
  - R-type (op 000000) by funct: addu 100001, subu 100011, and 100100, or 100101, slt 101010, sltu 101011, sll 000000, jr 001000.
  - I/J-type: addiu 001001, slti 001010, sltiu 001011, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
- EX:
  - R-ALU: alu_src_a=01 (10 for sll), alu_src_b=00. alu_op per funct: addu ADD, subu SUB, and AND, or OR, slt SLT, sltu SLTU, sll SLL. Next WB.
  - addiu/slti/sltiu/lui: alu_src_a=01, alu_src_b=10, alu_op ADD/SLT/SLTU/LUI. Next WB.
  - lw/sw: alu_src_a=01, alu_src_b=10, ADD. Next MEM.
  - beq/bne: alu_src_a=01, alu_src_b=00, SUB, pc_src=01. pc_write=alu_zero (beq) or !alu_zero (bne). Next IF.
  - j: pc_write=1, pc_src=10. Next IF.
  - jal: pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. The PC already holds PC+4, which is the value written. Next IF.
  - jr: pc_write=1, pc_src=11. Next IF.
- MEM:
  - lw: mem_read=1 until mem_ready; then next WB.
  - sw: mem_write=1 until mem_ready; then next IF.
  - mem_ready is sampled only in MEM. Read and write are never asserted together.
- WB: reg_write=1.
  - R-ALU: reg_dst=01, mem_to_reg=00.
  - I-ALU: reg_dst=00, mem_to_reg=00.
  - lw: reg_dst=00, mem_to_reg=01.
  - Next IF.
- opcode/funct must stay stable from ID through WB (IR only written in IF).
- Reset mid-operation: immediate return to INIT. No pending request survives.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - cycle_cnt out 32: increments every cycle after INIT.
  - retire_cnt out 32: increments on the transition into IF from ID (illegal only), EX, MEM or WB.
- Both reset to 0 and wrap modulo 2^32.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset released, inst_ready held 0 for 3 cycles then 1 -> INIT for 1 cycle; inst_req=1 for 4 cycles; ir_write=pc_write=1 only in the 4th IF cycle.
- addu (op 0, funct 100001), inst_ready immediate -> IF,ID,EX,WB. EX alu_op=010, src_a=01, src_b=00. WB reg_write=1, reg_dst=01.
- lw with mem_ready delayed 2 cycles -> mem_read high 3 cycles, then WB with mem_to_reg=01, reg_dst=00. sw -> mem_write only, returns to IF without reg_write.
- beq with alu_zero=1 -> pc_write=1, pc_src=01 in EX. Same beq with alu_zero=0 -> pc_write=0. bne with alu_zero=0 -> pc_write=1.
- jal -> EX pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. sll -> alu_src_a=10, alu_op=011. lui -> alu_op=101.
- opcode 111111 -> illegal=1 after ID and stays 1 through following instructions. resetn pulse low in MEM -> mem_read drops immediately and illegal clears.
